axilite_reg_slave: RTL

AXI4-Lite responder terminating the regSData register bus driven by the team's AXI-Lite master VIP. It owns a bank of software-writable control registers, presented as a flat output bus, and exposes a bank of read-only status inputs on the same address map. Its main role is the write-A / loop-to-B / read-back-B self-check: reg_out feeds reg_in externally, and the master reads the value back through this block.

---
 rtl/axilite_pkg.sv | 19 +
 rtl/axilite_reg_slave_if.sv | 30 +++
 rtl/axilite_read_mux.sv | 29 ++
 rtl/axilite_reg_slave.sv | 100 ++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// axilite_pkg: shared AXI4-Lite response codes, widths and the byte-lane merge helper.
package axilite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    function automatic logic [AXIL_DATA_W-1:0] byte_merge(
        input logic [AXIL_DATA_W-1:0] cur,
        input logic [AXIL_DATA_W-1:0] wd,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] r;
        r = cur;
        for (int b = 0; b < AXIL_STRB_W; b++)
            r[8*b +: 8] = strb[b] ? wd[8*b +: 8] : cur[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axilite_reg_slave_if.sv
// axilite_reg_slave_if: AXI4-Lite regSData bus bundle with master and slave views.
interface axilite_reg_slave_if
    import axilite_pkg::*;
#(
    parameter int ADDR_W = 20
) ();
    logic                   awvalid, awready;
    logic [ADDR_W-1:0]      awaddr;
    logic [2:0]             awprot;
    logic                   wvalid, wready;
    logic [AXIL_DATA_W-1:0] wdata;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic                   bvalid, bready;
    logic [1:0]             bresp;
    logic                   arvalid, arready;
    logic [ADDR_W-1:0]      araddr;
    logic [2:0]             arprot;
    logic                   rvalid, rready;
    logic [AXIL_DATA_W-1:0] rdata;
    logic [1:0]             rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_read_mux.sv
// axilite_read_mux: word index to {data, resp} over writable then status registers.
module axilite_read_mux
    import axilite_pkg::*;
#(
    parameter int IDX_W  = 18,
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 4
) (
    input  logic [IDX_W-1:0]              idx,
    input  logic [NUM_WR*AXIL_DATA_W-1:0] reg_wr,
    input  logic [NUM_RD*AXIL_DATA_W-1:0] reg_rd,
    output logic [AXIL_DATA_W-1:0]        data,
    output logic [1:0]                    resp
);
    always_comb begin
        data = '0;
        resp = RESP_SLVERR;
        for (int i = 0; i < NUM_WR; i++)
            if (idx == IDX_W'(i)) begin
                data = reg_wr[i*AXIL_DATA_W +: AXIL_DATA_W];
                resp = RESP_OKAY;
            end
        for (int i = 0; i < NUM_RD; i++)
            if (idx == IDX_W'(NUM_WR + i)) begin
                data = reg_rd[i*AXIL_DATA_W +: AXIL_DATA_W];
                resp = RESP_OKAY;
            end
    end
endmodule

// File: rtl/axilite_reg_slave.sv
// axilite_reg_slave: AXI4-Lite responder with writable control registers and read-only status inputs.
module axilite_reg_slave
    import axilite_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axilite_reg_slave_if.slave            s,
    output logic [NUM_WR*AXIL_DATA_W-1:0] reg_out,
    input  logic [NUM_RD*AXIL_DATA_W-1:0] reg_in,
    output logic [NUM_WR-1:0]             wr_pulse
);
    localparam int IDX_W = ADDR_W - 2;

    logic                   aw_held, w_held;
    logic [IDX_W-1:0]       aw_idx;
    logic [AXIL_DATA_W-1:0] w_data;
    logic [AXIL_STRB_W-1:0] w_strb;
    logic                   commit, wr_legal;
    logic [NUM_WR-1:0]      wr_hit;
    logic [AXIL_DATA_W-1:0] rd_data;
    logic [1:0]             rd_resp;
    logic                   unused_bits;

    assign s.awready   = !aw_held;
    assign s.wready    = !w_held;
    assign s.arready   = !s.rvalid;
    assign commit      = aw_held && w_held && !s.bvalid;
    assign wr_legal    = aw_idx < IDX_W'(NUM_WR);
    assign wr_hit      = (commit && wr_legal) ? NUM_WR'(1) << aw_idx : '0;
    assign unused_bits = ^{s.awaddr[1:0], s.araddr[1:0], s.awprot, s.arprot};

    // Commit only when the previous response has drained, so bresp never changes under a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            s.bvalid <= 1'b0;
            s.bresp  <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_hit;
            if (s.awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_idx  <= s.awaddr[ADDR_W-1:2];
            end
            if (s.wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s.bvalid <= 1'b1;
                s.bresp  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
            end else if (s.bvalid && s.bready) begin
                s.bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_out <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++)
                if (wr_hit[i])
                    reg_out[i*AXIL_DATA_W +: AXIL_DATA_W] <= byte_merge(reg_out[i*AXIL_DATA_W +: AXIL_DATA_W], w_data, w_strb);
        end
    end

    axilite_read_mux #(.IDX_W(IDX_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD)) u_read_mux (
        .idx    (s.araddr[ADDR_W-1:2]),
        .reg_wr (reg_out),
        .reg_rd (reg_in),
        .data   (rd_data),
        .resp   (rd_resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.rvalid <= 1'b0;
            s.rdata  <= '0;
            s.rresp  <= RESP_OKAY;
        end else if (s.arvalid && !s.rvalid) begin
            s.rvalid <= 1'b1;
            s.rdata  <= rd_data;
            s.rresp  <= rd_resp;
        end else if (s.rvalid && s.rready) begin
            s.rvalid <= 1'b0;
        end
    end
endmodule
